// File: rtl/vend_pkg.sv
// Shared types and helpers for the vending controller slice.
package vend_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CHECK    = 2'd1,
    DISPENSE = 2'd2,
    ERROR    = 2'd3
  } state_t;

  localparam int unsigned N_SLOTS     = 4;
  localparam int unsigned DEF_PRICE_W = 8;
  localparam int unsigned DEF_STOCK_W = 4;
  localparam int unsigned MAX_PRICE_W = 32;
  localparam int unsigned PIDX_W      = $clog2(N_SLOTS * MAX_PRICE_W);

  // Extracts slot idx from a flat price vector packed at stride w (w <= MAX_PRICE_W).
  function automatic logic [MAX_PRICE_W-1:0] price_at(
    input logic [N_SLOTS*MAX_PRICE_W-1:0] prices,
    input int unsigned                    w,
    input logic [1:0]                     idx
  );
    logic [MAX_PRICE_W-1:0] p;
    logic [PIDX_W-1:0]      bi;
    p  = '0;
    bi = '0;
    for (int unsigned b = 0; b < MAX_PRICE_W; b++) begin
      if (b < w) begin
        bi = PIDX_W'(32'(idx) * w + b);
        p[b] = prices[bi];
      end
    end
    return p;
  endfunction

  function automatic logic [N_SLOTS-1:0] slot_onehot(input logic [1:0] idx);
    return N_SLOTS'(1) << idx;
  endfunction

endpackage

// File: rtl/vend_controller_slot_arbiter.sv
// Slot request arbiter: round-robin when VEND_RR_EN is defined, else fixed lowest-index priority.
module slot_arbiter
  import vend_pkg::*;
(
  input  logic [N_SLOTS-1:0] req,
  input  logic [1:0]         ptr,
  output logic               grant_valid,
  output logic [1:0]         grant_idx
);

  logic       found;
  logic [1:0] cand;

`ifdef VEND_RR_EN
  logic [1:0] start;

  always_comb begin
    start       = ptr + 2'd1;
    grant_valid = |req;
    grant_idx   = '0;
    found       = 1'b0;
    cand        = start;
    for (int unsigned i = 0; i < N_SLOTS; i++) begin
      cand = start + 2'(i);
      if (!found && req[cand]) begin
        grant_idx = cand;
        found     = 1'b1;
      end
    end
  end
`else
  logic unused_ptr;
  assign unused_ptr = ^ptr;

  always_comb begin
    grant_valid = |req;
    grant_idx   = '0;
    found       = 1'b0;
    cand        = '0;
    for (int unsigned i = 0; i < N_SLOTS; i++) begin
      cand = 2'(i);
      if (!found && req[cand]) begin
        grant_idx = cand;
        found     = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/vend_controller.sv
// Vending sequencer: pending buy requests, arbitration, stock/balance check, deduct and dispense.
// Optional round-robin grant selected by VEND_RR_EN (see slot_arbiter).
module vend_controller
  import vend_pkg::*;
#(
  parameter int unsigned                   PRICE_W     = DEF_PRICE_W,
  parameter logic [N_SLOTS*PRICE_W-1:0]    PRICES      = {8'd20, 8'd15, 8'd10, 8'd5},
  parameter int unsigned                   STOCK_W     = DEF_STOCK_W,
  parameter int unsigned                   INIT_STOCK  = 5,
  parameter int unsigned                   DISP_CYCLES = 3
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [N_SLOTS-1:0] buy_pulse,
  input  logic [PRICE_W-1:0] balance,
  input  logic               restock,
  output logic               deduct,
  output logic [PRICE_W-1:0] deduct_amt,
  output logic [N_SLOTS-1:0] dispense,
  output logic               busy,
  output logic               err_funds,
  output logic               err_stock,
  output logic [N_SLOTS-1:0] stock_empty
);

  localparam int unsigned CNT_W = ($clog2(DISP_CYCLES) > 0) ? $clog2(DISP_CYCLES) : 1;

  state_t             state, state_nxt;
  logic [N_SLOTS-1:0] pending, pending_nxt;
  logic [1:0]         sel, sel_nxt;
  logic [1:0]         rr_ptr;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [STOCK_W-1:0] stock [N_SLOTS];
  logic [STOCK_W-1:0] stock_nxt [N_SLOTS];
  logic               deduct_nxt, err_funds_nxt, err_stock_nxt;
  logic [PRICE_W-1:0] deduct_amt_nxt, price_sel;
  logic [N_SLOTS-1:0] dispense_nxt;
  logic               grant_valid, grant_take;
  logic [1:0]         grant_idx;

  slot_arbiter u_arb (
    .req         (pending),
    .ptr         (rr_ptr),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

`ifdef VEND_RR_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)        rr_ptr <= 2'd3;
    else if (grant_take) rr_ptr <= grant_idx;
  end
`else
  assign rr_ptr = 2'd3;
`endif

  assign price_sel = PRICE_W'(price_at((N_SLOTS*MAX_PRICE_W)'(PRICES), PRICE_W, sel));
  assign busy      = (state != IDLE);

  always_comb begin
    stock_empty = '0;
    for (int unsigned i = 0; i < N_SLOTS; i++) stock_empty[i] = (stock[i] == '0);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      pending    <= '0;
      sel        <= '0;
      cnt        <= '0;
      deduct     <= 1'b0;
      deduct_amt <= '0;
      dispense   <= '0;
      err_funds  <= 1'b0;
      err_stock  <= 1'b0;
      for (int unsigned i = 0; i < N_SLOTS; i++) stock[i] <= STOCK_W'(INIT_STOCK);
    end else begin
      state      <= state_nxt;
      pending    <= pending_nxt;
      sel        <= sel_nxt;
      cnt        <= cnt_nxt;
      deduct     <= deduct_nxt;
      deduct_amt <= deduct_amt_nxt;
      dispense   <= dispense_nxt;
      err_funds  <= err_funds_nxt;
      err_stock  <= err_stock_nxt;
      for (int unsigned i = 0; i < N_SLOTS; i++) stock[i] <= stock_nxt[i];
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:     if (grant_valid) state_nxt = CHECK;
      CHECK:    state_nxt = ((stock[sel] == '0) || (balance < price_sel)) ? ERROR : DISPENSE;
      DISPENSE: if (cnt == '0) state_nxt = IDLE;
      ERROR:    state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    deduct_nxt     = 1'b0;
    deduct_amt_nxt = '0;
    err_funds_nxt  = 1'b0;
    err_stock_nxt  = 1'b0;
    dispense_nxt   = dispense;
    cnt_nxt        = cnt;
    sel_nxt        = sel;
    grant_take     = 1'b0;
    stock_nxt      = stock;
    unique case (state)
      IDLE: begin
        if (grant_valid) begin
          sel_nxt    = grant_idx;
          grant_take = 1'b1;
        end
      end
      CHECK: begin
        if (stock[sel] == '0) begin
          err_stock_nxt = 1'b1;
        end else if (balance < price_sel) begin
          err_funds_nxt = 1'b1;
        end else begin
          deduct_nxt     = 1'b1;
          deduct_amt_nxt = price_sel;
          dispense_nxt   = slot_onehot(sel);
          stock_nxt[sel] = stock[sel] - STOCK_W'(1);
          cnt_nxt        = CNT_W'(DISP_CYCLES - 1);
        end
      end
      DISPENSE: begin
        if (cnt == '0) dispense_nxt = '0;
        else           cnt_nxt      = cnt - CNT_W'(1);
      end
      default: ;
    endcase
    // Buy set wins over grant clear; restock wins over a coincident decrement.
    pending_nxt = (pending & ~(grant_take ? slot_onehot(grant_idx) : '0)) | buy_pulse;
    if (restock) begin
      for (int unsigned i = 0; i < N_SLOTS; i++) stock_nxt[i] = STOCK_W'(INIT_STOCK);
    end
  end

endmodule

// File: tb/tb_vend_controller.sv
// Directed self-checking bench for vend_controller; expectations follow VEND_RR_EN if defined.
module tb_vend_controller;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] buy_pulse;
  logic [7:0] balance;
  logic       restock;
  logic       deduct;
  logic [7:0] deduct_amt;
  logic [3:0] dispense;
  logic       busy;
  logic       err_funds;
  logic       err_stock;
  logic [3:0] stock_empty;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  vend_controller #(
    .PRICE_W     (8),
    .PRICES      ({8'd20, 8'd15, 8'd10, 8'd5}),
    .STOCK_W     (4),
    .INIT_STOCK  (5),
    .DISP_CYCLES (3)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .buy_pulse   (buy_pulse),
    .balance     (balance),
    .restock     (restock),
    .deduct      (deduct),
    .deduct_amt  (deduct_amt),
    .dispense    (dispense),
    .busy        (busy),
    .err_funds   (err_funds),
    .err_stock   (err_stock),
    .stock_empty (stock_empty)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int unsigned n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [3:0] m);
    buy_pulse = m;
    step(1);
    buy_pulse = '0;
  endtask

  initial begin
    logic [3:0] first_rr, second_rr;
`ifdef VEND_RR_EN
    first_rr  = 4'b0100;
    second_rr = 4'b0001;
`else
    first_rr  = 4'b0001;
    second_rr = 4'b0100;
`endif
    reset_n   = 1'b0;
    buy_pulse = '0;
    balance   = '0;
    restock   = 1'b0;
    step(2);
    chk("rst_busy", busy, 0);
    chk("rst_dispense", dispense, 0);
    chk("rst_deduct", deduct, 0);
    chk("rst_stock_empty", stock_empty, 0);
    chk("rst_pending", dut.pending, 0);
    chk("rst_stock0", dut.stock[0], 5);
    reset_n = 1'b1;
    step(1);

    // Vend OK: slot1, price 10, balance 20
    balance = 8'd20;
    pulse(4'b0010);
    chk("ok_pending_c1", dut.pending, 4'b0010);
    chk("ok_busy_c1", busy, 0);
    step(1);
    chk("ok_busy_c2", busy, 1);
    chk("ok_deduct_c2", deduct, 0);
    step(1);
    chk("ok_deduct_c3", deduct, 1);
    chk("ok_amt_c3", deduct_amt, 10);
    chk("ok_disp_c3", dispense, 4'b0010);
    chk("ok_stock1", dut.stock[1], 4);
    step(1);
    chk("ok_deduct_c4", deduct, 0);
    chk("ok_amt_c4", deduct_amt, 0);
    chk("ok_disp_c4", dispense, 4'b0010);
    step(1);
    chk("ok_disp_c5", dispense, 4'b0010);
    step(1);
    chk("ok_disp_c6", dispense, 0);
    chk("ok_busy_c6", busy, 0);

    // Insufficient funds: slot0 price 5, balance 4
    balance = 8'd4;
    pulse(4'b0001);
    step(2);
    chk("nf_err_c3", err_funds, 1);
    chk("nf_deduct_c3", deduct, 0);
    chk("nf_disp_c3", dispense, 0);
    step(1);
    chk("nf_err_c4", err_funds, 0);
    chk("nf_busy_c4", busy, 0);
    chk("nf_stock0", dut.stock[0], 5);

    // Exact balance equals price: vend succeeds
    balance = 8'd5;
    pulse(4'b0001);
    step(2);
    chk("eq_deduct", deduct, 1);
    chk("eq_amt", deduct_amt, 5);
    chk("eq_err", err_funds, 0);
    step(3);
    chk("eq_stock0", dut.stock[0], 4);

    // Sold out on slot3
    balance = 8'd255;
    for (int k = 0; k < 5; k++) begin
      pulse(4'b1000);
      step(5);
      chk("so_stock_empty", stock_empty, (k == 4) ? 4'b1000 : 4'b0000);
    end
    chk("so_stock3", dut.stock[3], 0);
    pulse(4'b1000);
    step(2);
    chk("so_err_stock", err_stock, 1);
    chk("so_err_funds", err_funds, 0);
    chk("so_disp", dispense, 0);
    chk("so_deduct", deduct, 0);
    step(1);
    chk("so_err_clear", err_stock, 0);
    chk("so_stock3_hold", dut.stock[3], 0);
    restock = 1'b1;
    step(1);
    restock = 1'b0;
    chk("rs_stock_empty", stock_empty, 0);
    chk("rs_stock3", dut.stock[3], 5);
    chk("rs_stock1", dut.stock[1], 5);
    chk("rs_stock0", dut.stock[0], 5);

    // Simultaneous requests on all slots
    pulse(4'b1111);
    chk("all_pending", dut.pending, 4'b1111);
    step(2);
    chk("all_g0", dispense, 4'b0001);
    step(5);
    chk("all_g1", dispense, 4'b0010);
    step(5);
    chk("all_g2", dispense, 4'b0100);
    step(5);
    chk("all_g3", dispense, 4'b1000);
    step(3);
    chk("all_idle", busy, 0);

    // Slot2 and slot0 both pending after a grant to slot0
    buy_pulse = 4'b0001;
    step(1);
    buy_pulse = 4'b0100;
    step(1);
    buy_pulse = 4'b0001;
    step(1);
    buy_pulse = '0;
    chk("rr_pending", dut.pending, 4'b0101);
    chk("rr_g0", dispense, 4'b0001);
    step(5);
    chk("rr_first", dispense, first_rr);
    step(5);
    chk("rr_second", dispense, second_rr);
    step(3);
    chk("rr_idle", busy, 0);

    // Duplicate buys on slot1 while busy are absorbed
    pulse(4'b0001);
    step(2);
    buy_pulse = 4'b0010;
    step(1);
    buy_pulse = 4'b0010;
    step(1);
    buy_pulse = '0;
    chk("dup_pending", dut.pending, 4'b0010);
    step(3);
    chk("dup_disp", dispense, 4'b0010);
    step(3);
    chk("dup_idle", busy, 0);
    step(1);
    chk("dup_no_second", busy, 0);
    chk("dup_pending_clr", dut.pending, 0);
    chk("dup_stock1", dut.stock[1], 3);

    // Async reset mid-dispense
    pulse(4'b0100);
    step(2);
    chk("ar_disp_pre", dispense, 4'b0100);
    buy_pulse = 4'b0001;
    step(1);
    buy_pulse = '0;
    #2;
    reset_n = 1'b0;
    #1;
    chk("ar_disp", dispense, 0);
    chk("ar_busy", busy, 0);
    chk("ar_pending", dut.pending, 0);
    for (int i = 0; i < 4; i++) chk("ar_stock", dut.stock[i], 5);
    step(1);
    reset_n = 1'b1;
    step(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
